// File: rtl/async_ram_16x8_pkg.sv
// async_ram_16x8_pkg
//   Shared constants, the operation enum and the op decoder for the 16x8
//   asynchronous-read RAM.
//   Build macro: ASYNC_RAM_VALID_EN (used by the top, not by this package).
//   Contents:
//     DATA_W, ADDR_W, DEPTH  geometry of the store
//     op_e                   IDLE / WRITE / READ / CONFLICT
//     op_decode(we, enable)  maps the two strobes onto op_e
package async_ram_16x8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_WRITE,
    OP_READ,
    OP_CONFLICT
  } op_e;

  // Both strobes high is a conflict and is treated as a no-op by the RAM,
  // so it never writes and never drives the bus.
  function automatic op_e op_decode(input logic we, input logic enable);
    case ({we, enable})
      2'b00:   op_decode = OP_IDLE;
      2'b10:   op_decode = OP_WRITE;
      2'b01:   op_decode = OP_READ;
      default: op_decode = OP_CONFLICT;
    endcase
  endfunction

endpackage

// File: rtl/async_ram_16x8_if.sv
// async_ram_16x8_if
//   Control side of the RAM bus: strobes and address from the bus master,
//   plus the RAM's data drive-enable so a master can see when the RAM owns
//   the shared data lines. The data lines themselves stay a plain inout
//   port on the RAM so tri-state resolution happens on a real net.
//   Build macro: ASYNC_RAM_VALID_EN (no effect on this interface).
//   Signals:
//     we       master -> RAM  write strobe
//     enable   master -> RAM  read enable
//     addr     master -> RAM  word address
//     data_oe  RAM -> master  high while the RAM drives the data bus
interface async_ram_16x8_if;
  import async_ram_16x8_pkg::*;

  logic              we;
  logic              enable;
  logic [ADDR_W-1:0] addr;
  logic              data_oe;

  modport master (output we, output enable, output addr, input data_oe);
  modport slave  (input we, input enable, input addr, output data_oe);

endinterface

// File: rtl/async_ram_16x8_array.sv
// async_ram_16x8_array
//   Clocked storage for the 16x8 RAM with a synchronous clear and an
//   asynchronous (combinational) read port.
//   Build macro: ASYNC_RAM_VALID_EN (no effect on this module).
//   Ports:
//     clk      in   rising-edge clock
//     rst      in   synchronous active-high clear of every word
//     we_i     in   commit wdata_i to addr_i at the edge (already decoded)
//     addr_i   in   word address for both write and read
//     wdata_i  in   write data
//     rdata_o  out  mem[addr_i], combinational
module async_ram_16x8_array
  import async_ram_16x8_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reset wins over a concurrent write, so the write in the reset cycle is
  // simply dropped rather than landing on top of the cleared array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read port sees only committed contents, never the incoming write data.
  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/async_ram_16x8.sv
// async_ram_16x8
//   16-word x 8-bit RAM on a single bidirectional data bus. Writes commit on
//   the rising clock edge; reads are combinational from address to bus.
//   Build macro: ASYNC_RAM_VALID_EN
//     defined   : per-word valid bits, rd_valid_o port, and never-written
//                 words read back as 8'h00
//     undefined : plain store, reads return the stored word
//   Ports:
//     clk         in     rising-edge clock
//     rst         in     synchronous active-high reset (clears all words)
//     bus         slave  we / enable / addr in, data_oe out
//     data_io     inout  shared data bus, driven only while op is READ
//     rd_valid_o  out    (ASYNC_RAM_VALID_EN only) READ of a written word
module async_ram_16x8
  import async_ram_16x8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  async_ram_16x8_if.slave       bus,
  inout  wire  [DATA_W-1:0]     data_io
`ifdef ASYNC_RAM_VALID_EN
  ,
  output logic                  rd_valid_o
`endif
);

  op_e               op;
  logic              isRead;
  logic              isWrite;
  logic [DATA_W-1:0] rawData;
  logic [DATA_W-1:0] rdData;

  assign op      = op_decode(bus.we, bus.enable);
  assign isRead  = (op == OP_READ);
  assign isWrite = (op == OP_WRITE);

  async_ram_16x8_array u_array (
    .clk     (clk),
    .rst     (rst),
    .we_i    (isWrite),
    .addr_i  (bus.addr),
    .wdata_i (data_io),
    .rdata_o (rawData)
  );

`ifdef ASYNC_RAM_VALID_EN
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  always_comb begin
    valid_d = valid_q;
    if (isWrite) begin
      valid_d[bus.addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // A word that has not been written since reset reads as zero.
  assign rdData     = valid_q[bus.addr] ? rawData : '0;
  assign rd_valid_o = isRead && valid_q[bus.addr];
`else
  assign rdData = rawData;
`endif

  // The RAM owns the bus only for READ; WRITE, IDLE and CONFLICT release it.
  assign bus.data_oe = isRead;
  assign data_io     = isRead ? rdData : {DATA_W{1'bz}};

endmodule

// File: tb/tb_async_ram_16x8.sv
// tb_async_ram_16x8
//   Directed bench for async_ram_16x8 with a word-array reference model and
//   a negedge compare process, plus literal expectations in the directed flow.
//   Build macro: ASYNC_RAM_VALID_EN (adds rd_valid checks when defined).
module tb_async_ram_16x8;

  logic       clk;
  logic       rst;
  logic [7:0] tbDrive;
  logic       tbDriveEn;
  wire  [7:0] dataBus;
  logic       checking;
  int         checkCount;
  int         passCount;

  logic [7:0] modelMem   [16];
  logic       modelValid [16];

`ifdef ASYNC_RAM_VALID_EN
  logic rdValid;
`endif

  async_ram_16x8_if ramIf ();

  assign dataBus = tbDriveEn ? tbDrive : 8'hzz;

  async_ram_16x8 dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (ramIf.slave),
    .data_io (dataBus)
`ifdef ASYNC_RAM_VALID_EN
    ,
    .rd_valid_o (rdValid)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference store: cleared by reset, otherwise updated by a lone write strobe
  // with whatever the bench put on the bus.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        modelMem[i]   <= 8'h00;
        modelValid[i] <= 1'b0;
      end
    end else if (ramIf.we && !ramIf.enable && tbDriveEn) begin
      modelMem[ramIf.addr]   <= tbDrive;
      modelValid[ramIf.addr] <= 1'b1;
    end
  end

  function automatic logic [7:0] modelRead(input logic [3:0] a);
`ifdef ASYNC_RAM_VALID_EN
    return modelValid[a] ? modelMem[a] : 8'h00;
`else
    return modelMem[a];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Mid-cycle comparison of everything the RAM presents against the model.
  always @(negedge clk) begin
    if (checking) begin
      logic expRead;
      expRead = ramIf.enable && !ramIf.we;
      checkOutput("cmp_oe", {7'd0, ramIf.data_oe}, {7'd0, expRead});
      if (expRead) begin
        checkOutput("cmp_read", dataBus, modelRead(ramIf.addr));
      end
      if (ramIf.we && !ramIf.enable && tbDriveEn) begin
        checkOutput("cmp_wrbus", dataBus, tbDrive);
      end
`ifdef ASYNC_RAM_VALID_EN
      checkOutput("cmp_rdvalid", {7'd0, rdValid}, {7'd0, expRead && modelValid[ramIf.addr]});
`endif
    end
  end

  task automatic applyStimulus(input logic r, input logic w, input logic e,
                               input logic [3:0] a, input logic drv, input logic [7:0] d);
    rst          = r;
    ramIf.we     = w;
    ramIf.enable = e;
    ramIf.addr   = a;
    tbDriveEn    = drv;
    tbDrive      = d;
  endtask

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic writeCycle(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, 1'b1, d);
    nextCycle();
  endtask

  task automatic readCheck(input string name, input logic [3:0] a, input logic [7:0] expected);
    applyStimulus(1'b0, 1'b0, 1'b1, a, 1'b0, 8'h00);
    #2;
    checkOutput(name, dataBus, expected);
    nextCycle();
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    checking   = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    nextCycle();
    checking = 1'b1;

    // Reset state: idle bus released, then every word reads zero.
    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    #2;
    checkOutput("reset_idle_oe", {7'd0, ramIf.data_oe}, 8'h00);
    nextCycle();
    for (int i = 0; i < 16; i++) begin
      readCheck("reset_read", 4'(i), 8'h00);
    end

    // Identity fill and read-back.
    for (int i = 0; i < 16; i++) begin
      writeCycle(4'(i), 8'(i));
    end
    for (int i = 0; i < 16; i++) begin
      readCheck("fill_read", 4'(i), 8'(i));
    end

    // Address change inside one cycle is tracked combinationally.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00);
    #2;
    checkOutput("addr_track_a", dataBus, 8'h05);
    ramIf.addr = 4'd6;
    #1;
    checkOutput("addr_track_b", dataBus, 8'h06);
    nextCycle();

    // Conflict never writes and never drives.
    writeCycle(4'd3, 8'hA5);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 8'h5A);
    #2;
    checkOutput("conflict_oe", {7'd0, ramIf.data_oe}, 8'h00);
    nextCycle();
    readCheck("conflict_keep", 4'd3, 8'hA5);

    // Reset beats a concurrent write.
    writeCycle(4'd7, 8'h3C);
    readCheck("pre_rst_read", 4'd7, 8'h3C);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 8'hFF);
    nextCycle();
    readCheck("rst_over_write", 4'd7, 8'h00);

    // A read during reset shows pre-edge contents, then zero.
    writeCycle(4'd4, 8'h77);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'd4, 1'b0, 8'h00);
    #2;
    checkOutput("rst_read_pre", dataBus, 8'h77);
    nextCycle();
    readCheck("rst_read_post", 4'd4, 8'h00);

    // Idle at several addresses and a write phase leave the bus to the master.
    for (int i = 0; i < 16; i += 5) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4'(i), 1'b0, 8'h00);
      #2;
      checkOutput("idle_oe", {7'd0, ramIf.data_oe}, 8'h00);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 8'hC3);
    #2;
    checkOutput("write_bus", dataBus, 8'hC3);
    nextCycle();
    readCheck("write_commit", 4'd9, 8'hC3);

    // Wrap from the top address to address zero.
    writeCycle(4'd15, 8'hF0);
    writeCycle(4'd0, 8'h0F);
    readCheck("wrap_hi", 4'd15, 8'hF0);
    readCheck("wrap_lo", 4'd0, 8'h0F);

    // Valid tracking after a fresh reset.
    applyStimulus(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    nextCycle();
    writeCycle(4'd2, 8'h11);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 8'h00);
    #2;
    checkOutput("valid_read_data", dataBus, 8'h11);
`ifdef ASYNC_RAM_VALID_EN
    checkOutput("valid_read_flag", {7'd0, rdValid}, 8'h01);
`endif
    nextCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 8'h00);
    #2;
    checkOutput("unwritten_data", dataBus, 8'h00);
`ifdef ASYNC_RAM_VALID_EN
    checkOutput("unwritten_flag", {7'd0, rdValid}, 8'h00);
`endif
    nextCycle();

    applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    nextCycle();
    checking = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
